// File: rtl/fbc_pkg.sv
// Shared types and constants for the four-bit comparator scheduler.
package fbc_pkg;

    localparam int OPND_W      = 4;
    localparam int NUM_REQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESPOND = 2'd2
    } fbc_state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_result_t;

endpackage

// File: rtl/fbc_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
// Produces a one-hot grant and its encoded index; all zero when disabled.
module fbc_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);

    int   cand;
    logic found;

    // Search NUM_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (en && !found && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand[ID_W-1:0];
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/four_bit_comparator.sv
// Plain unsigned 4-bit magnitude comparator; exactly one output is high.
module four_bit_comparator (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/fbc_scheduler.sv
// Time-shares one four_bit_comparator between NUM_REQ requesters.
// Optional build macro FBC_SCHED_SIGNED_EN: operands compared as 4-bit
// two's complement by flipping their sign bits ahead of the comparator.
//
// Handshakes: a request from requester k transfers on a rising edge where
// i_REQ_VALID[k] and o_REQ_READY[k] are both high; the response transfers on
// a rising edge where o_RSP_VALID and i_RSP_READY are both high. Valid never
// depends on ready, and response fields are stable while valid waits.
module fbc_scheduler
    import fbc_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = 2
) (
    input  logic                      i_CLK,
    input  logic                      i_RST_N,
    input  logic [NUM_REQ-1:0]        i_REQ_VALID,
    input  logic [OPND_W*NUM_REQ-1:0] i_REQ_A,
    input  logic [OPND_W*NUM_REQ-1:0] i_REQ_B,
    output logic [NUM_REQ-1:0]        o_REQ_READY,
    output logic                      o_RSP_VALID,
    input  logic                      i_RSP_READY,
    output logic [ID_W-1:0]           o_RSP_ID,
    output logic                      o_RSP_GT,
    output logic                      o_RSP_EQ,
    output logic                      o_RSP_LT,
    output logic                      o_BUSY,
    output fbc_state_t                o_DBG_STATE
);

    fbc_state_t         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d, gnt_idx, id_q;
    logic [NUM_REQ-1:0] gnt;
    logic [OPND_W-1:0]  a_q, b_q, cmp_a, cmp_b;
    cmp_result_t        res_q, cmp_res;
    logic               rsp_valid_q, accept, arb_en;
    logic               cmp_gt, cmp_eq, cmp_lt;

    // Grants only offered from IDLE and never while reset is held.
    assign arb_en = (state_q == IDLE) && i_RST_N;
    assign accept = |gnt;

    fbc_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req (i_REQ_VALID),
        .ptr (rr_ptr_q),
        .en  (arb_en),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef FBC_SCHED_SIGNED_EN
    // Flipping the sign bit maps two's complement order onto unsigned order.
    assign cmp_a = {~a_q[OPND_W-1], a_q[OPND_W-2:0]};
    assign cmp_b = {~b_q[OPND_W-1], b_q[OPND_W-2:0]};
`else
    assign cmp_a = a_q;
    assign cmp_b = b_q;
`endif

    four_bit_comparator u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .gt (cmp_gt),
        .eq (cmp_eq),
        .lt (cmp_lt)
    );

    assign cmp_res = '{gt: cmp_gt, eq: cmp_eq, lt: cmp_lt};

    // Next-state: one cycle to compare, then hold until the result is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = COMPARE;
            COMPARE: state_d = RESPOND;
            RESPOND: if (i_RSP_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Operand capture, round-robin pointer, result and response-valid registers.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q      <= i_REQ_A[int'(gnt_idx)*OPND_W +: OPND_W];
                b_q      <= i_REQ_B[int'(gnt_idx)*OPND_W +: OPND_W];
                id_q     <= gnt_idx;
                rr_ptr_q <= rr_ptr_d;
            end
            if (state_q == COMPARE) begin
                res_q       <= cmp_res;
                rsp_valid_q <= 1'b1;
            end
            if (state_q == RESPOND && i_RSP_READY) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign o_REQ_READY = gnt;
    assign o_RSP_VALID = rsp_valid_q;
    assign o_RSP_ID    = id_q;
    assign o_RSP_GT    = res_q.gt;
    assign o_RSP_EQ    = res_q.eq;
    assign o_RSP_LT    = res_q.lt;
    assign o_BUSY      = (state_q != IDLE);
    assign o_DBG_STATE = state_q;

endmodule

// File: tb/tb_fbc_scheduler.sv
// Self-checking bench for fbc_scheduler: cycle model + response scoreboard.
module tb_fbc_scheduler;
    import fbc_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int RW = IW + 3;

    // ---------------- clock / reset ----------------
    logic i_CLK = 1'b0;
    logic i_RST_N = 1'b0;
    always #5 i_CLK = ~i_CLK;

    logic [N-1:0]   req_valid = '0;
    logic [4*N-1:0] req_a = '0;
    logic [4*N-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [IW-1:0]  rsp_id;
    logic           rsp_gt, rsp_eq, rsp_lt, busy;
    fbc_state_t     dbg_state;

    fbc_scheduler #(.NUM_REQ(N), .ID_W(IW)) dut (
        .i_CLK       (i_CLK),
        .i_RST_N     (i_RST_N),
        .i_REQ_VALID (req_valid),
        .i_REQ_A     (req_a),
        .i_REQ_B     (req_b),
        .o_REQ_READY (req_ready),
        .o_RSP_VALID (rsp_valid),
        .i_RSP_READY (rsp_ready),
        .o_RSP_ID    (rsp_id),
        .o_RSP_GT    (rsp_gt),
        .o_RSP_EQ    (rsp_eq),
        .o_RSP_LT    (rsp_lt),
        .o_BUSY      (busy),
        .o_DBG_STATE (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference compare: {gt, eq, lt}
    function automatic logic [2:0] model_cmp(input logic [3:0] a, input logic [3:0] b);
`ifdef FBC_SCHED_SIGNED_EN
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
`else
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
`endif
        return {sa > sb, sa == sb, sa < sb};
    endfunction

    function automatic logic [N-1:0] model_pick(input logic [N-1:0] v, input int ptr);
        logic [N-1:0] g;
        g = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[(ptr + i) % N]) begin
                g = '0;
                g[(ptr + i) % N] = 1'b1;
            end
        end
        return g;
    endfunction

    // ---------------- scoreboard / cycle model ----------------
    logic [RW-1:0] exp_q[$];
    int            gnt_log[$];
    int            m_state = 0;
    int            m_ptr = 0;
    bit            mon_en = 1'b0;
    bit            prev_hold = 1'b0;
    logic [RW-1:0] prev_rsp;
    logic [RW-1:0] cur_rsp;
    logic [RW-1:0] last_rsp = '0;
    logic [RW-1:0] exp_item;
    logic [N-1:0]  exp_rdy;
    int            k_gnt;

    // Sample at the falling edge, where inputs and outputs are settled.
    always @(negedge i_CLK) begin
        if (mon_en) begin
            exp_rdy = (i_RST_N && m_state == 0) ? model_pick(req_valid, m_ptr) : '0;
            check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
            check_eq("busy", 32'(busy), 32'(m_state != 0));
            check_eq("rsp_valid", 32'(rsp_valid), 32'(m_state == 2));
            cur_rsp = {rsp_id, rsp_gt, rsp_eq, rsp_lt};
            if (rsp_valid) check_eq("rsp_onehot", 32'($countones({rsp_gt, rsp_eq, rsp_lt})), 32'd1);
            if (prev_hold) check_eq("rsp_hold", 32'(cur_rsp), 32'(prev_rsp));
            prev_hold = 1'b0;
            if (!i_RST_N) begin
                m_state = 0;
                m_ptr   = 0;
                exp_q.delete();
            end else begin
                case (m_state)
                    0: if (|exp_rdy) begin
                        k_gnt = 0;
                        for (int i = 0; i < N; i++) if (exp_rdy[i]) k_gnt = i;
                        exp_item = {k_gnt[IW-1:0], model_cmp(req_a[4*k_gnt +: 4], req_b[4*k_gnt +: 4])};
                        exp_q.push_back(exp_item);
                        gnt_log.push_back(k_gnt);
                        m_ptr   = (k_gnt + 1) % N;
                        m_state = 1;
                    end
                    1: m_state = 2;
                    default: begin
                        if (rsp_ready) begin
                            if (exp_q.size() == 0) begin
                                check_eq("rsp_unexpected", 32'd1, 32'd0);
                            end else begin
                                exp_item = exp_q.pop_front();
                                check_eq("rsp", 32'(cur_rsp), 32'(exp_item));
                                last_rsp = cur_rsp;
                            end
                            m_state = 0;
                        end else begin
                            prev_hold = 1'b1;
                            prev_rsp  = cur_rsp;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        i_RST_N = 1'b0;
        repeat (cycles) step();
        i_RST_N = 1'b1;
    endtask

    // Raise one request and hold it until granted; returns in the COMPARE cycle.
    task automatic req_once(input int k, input logic [3:0] a, input logic [3:0] b);
        int base;
        base = gnt_log.size();
        req_a[4*k +: 4] = a;
        req_b[4*k +: 4] = b;
        req_valid[k] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step();
            if (gnt_log.size() > base) break;
        end
        req_valid[k] = 1'b0;
        if (gnt_log.size() == base) check_eq("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((m_state != 0 || exp_q.size() != 0) && c < 50) begin
            step();
            c++;
        end
        if (c >= 50) check_eq("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_grants(input int base, input int count);
        int c;
        c = 0;
        while (gnt_log.size() < base + count && c < 100) begin
            step();
            c++;
        end
        if (c >= 100) check_eq("grants_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    int base;

    initial begin
        req_valid = '1;
        repeat (3) step();
        check_eq("reset_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy}), 32'd0);
        mon_en = 1'b1;
        req_valid = '0;
        step();
        i_RST_N = 1'b1;
        step();

        // Single request, unsigned GT
        req_once(0, 4'd5, 4'd3);
        wait_idle();
        check_eq("single_rsp", 32'(last_rsp), 32'({2'd0, 3'b100}));

        // All four requesting from reset, equal operands
        apply_reset(2);
        for (int n = 0; n < N; n++) begin
            req_a[4*n +: 4] = 4'(n);
            req_b[4*n +: 4] = 4'(n);
        end
        base = gnt_log.size();
        req_valid = '1;
        wait_grants(base, 5);
        req_valid = '0;
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            if (base + i < gnt_log.size()) check_eq("rr_order", 32'(gnt_log[base+i]), 32'(i % N));
        end
        check_eq("rr_last_rsp", 32'(last_rsp), 32'({2'd0, 3'b010}));

        // Backpressure on the response
        rsp_ready = 1'b0;
        req_once(2, 4'd2, 4'd9);
        repeat (5) step();
        check_eq("bp_busy", 32'(busy), 32'd1);
        rsp_ready = 1'b1;
        wait_idle();
        check_eq("bp_rsp", 32'(last_rsp), 32'({2'd2, 3'b001}));

        // Reset while in COMPARE: no response, pointer back to 0
        req_once(3, 4'd8, 4'd1);
        i_RST_N = 1'b0;
        step();
        i_RST_N = 1'b1;
        #2;
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        base = gnt_log.size();
        req_valid = '1;
        wait_grants(base, 1);
        req_valid = '0;
        wait_idle();
        if (base < gnt_log.size()) check_eq("rst_first_grant", 32'(gnt_log[base]), 32'd0);

        // Fairness from rr_ptr = 2 with requesters 1 and 3; 2 only pulses while busy
        req_once(1, 4'd4, 4'd4);
        wait_idle();
        base = gnt_log.size();
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        for (int c = 0; c < 60 && gnt_log.size() < base + 3; c++) begin
            req_valid[2] = (m_state != 0);
            step();
        end
        req_valid = '0;
        wait_idle();
        check_eq("fair_count", 32'(gnt_log.size() - base), 32'd3);
        if (gnt_log.size() >= base + 3) begin
            check_eq("fair_g0", 32'(gnt_log[base]),   32'd3);
            check_eq("fair_g1", 32'(gnt_log[base+1]), 32'd1);
            check_eq("fair_g2", 32'(gnt_log[base+2]), 32'd3);
        end

        // Signedness of the compare
        req_once(0, 4'hF, 4'h1);
        wait_idle();
`ifdef FBC_SCHED_SIGNED_EN
        check_eq("signed_cmp", 32'(last_rsp[2:0]), 32'(3'b001));
`else
        check_eq("unsigned_cmp", 32'(last_rsp[2:0]), 32'(3'b100));
`endif

        // Random traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            req_a     = 16'($urandom_range(0, 65535));
            req_b     = 16'($urandom_range(0, 65535));
            rsp_ready = 1'($urandom_range(0, 1));
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fbc_scheduler.md
Name: fbc_scheduler

Overview:
- Time-shares one four_bit_comparator instance between NUM_REQ requesters.
- Round-robin arbitration; one compare in flight at a time.
- Each requester has a valid/ready request channel. All requesters share one valid/ready response channel, tagged with the requester ID.
- Sits between the compare-issuing agents and the shared comparator datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).

Ports:
- i_CLK  input  1  single clock; all logic on rising edge.
- i_RST_N  input  1  synchronous, active-low reset.
- i_REQ_VALID  input  NUM_REQ  per-requester request valid.
- i_REQ_A  input  4*NUM_REQ  operand A; requester n at bits [4n+3:4n].
- i_REQ_B  input  4*NUM_REQ  operand B; same packing as i_REQ_A.
- o_REQ_READY  output  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
- o_RSP_VALID  output  1  result valid.
- i_RSP_READY  input  1  consumer accepts the result.
- o_RSP_ID  output  ID_W  index of the requester that owns the result.
- o_RSP_GT  output  1  A > B.
- o_RSP_EQ  output  1  A == B.
- o_RSP_LT  output  1  A < B.
- o_BUSY  output  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, COMPARE, RESPOND.
- IDLE:
  - o_REQ_READY = the round-robin pick among asserted i_REQ_VALID bits, starting the search at rr_ptr.
  - o_REQ_READY is combinational from state, rr_ptr and i_REQ_VALID only. i_REQ_VALID must not depend on o_REQ_READY.
  - No valid requester → o_REQ_READY = 0 and the FSM stays in IDLE.
- Acceptance (cycle T, any requester k granted):
  - Latch A_k, B_k and ID = k.
  - rr_ptr ← (k+1) mod NUM_REQ.
  - Go to COMPARE.
- COMPARE (T+1):
  - The latched operands drive the comparator.
  - Register GT/EQ/LT and set o_RSP_VALID.
  - Go to RESPOND.
- RESPOND (T+2 onward):
  - o_RSP_VALID = 1.
  - o_RSP_ID, GT, EQ and LT are held stable until i_RSP_READY = 1.
  - On that handshake edge: o_RSP_VALID ← 0, go to IDLE.
  - Next grant is possible in the cycle after the handshake. Maximum throughput is one compare per 3 cycles.
- Latency: request acceptance to o_RSP_VALID is 2 cycles.
- Exactly one of GT/EQ/LT is high whenever o_RSP_VALID = 1.
- o_REQ_READY = 0 in COMPARE and RESPOND.
- A requester dropping valid while not granted is legal and has no effect.
- Requests made while busy wait for IDLE; no queueing beyond that.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Simultaneous requests on all inputs: service order from rr_ptr=0 is 0,1,2,3,0,...
- Reset (i_RST_N = 0 at a clock edge), including mid-operation:
  - state ← IDLE, rr_ptr ← 0.
  - o_RSP_VALID, GT, EQ, LT, o_RSP_ID ← 0.
  - o_REQ_READY = 0 while reset is asserted.
  - Any in-flight compare is discarded; no response is emitted for it.

Optional Feature:
- Macro: FBC_SCHED_SIGNED_EN.
- Defined:
  - Operands are interpreted as 4-bit two's complement.
  - Implemented by inverting bit 3 of both latched operands before the comparator. The comparator itself is unchanged.
  - Example: A=4'b1111 (-1), B=4'b0001 (+1) gives LT.
- Undefined: unsigned compare; the same inputs give GT.
- Timing and handshakes are identical in both builds.

Decomposition:
- Package fbc_pkg:
  - state enum {IDLE, COMPARE, RESPOND};
  - typedef cmp_result_t {gt, eq, lt};
  - constants OPND_W = 4 and the default NUM_REQ.
- Sub-module fbc_rr_arbiter:
  - inputs: request vector, rr_ptr, enable;
  - outputs: one-hot grant and encoded index.
- The scheduler top holds the FSM, the operand/result registers and the four_bit_comparator instance.

Test Plan:
- Single request: req0 valid, A=5, B=3.
  → ready0 high in cycle T; o_RSP_VALID at T+2 with ID=0, GT=1; i_RSP_READY=1 → back to IDLE at T+3.
- All four valid from reset, A_n = B_n = n.
  → grants in order 0,1,2,3, each response EQ=1; ID sequence 0,1,2,3; then wraps to 0.
- Backpressure: i_RSP_READY=0 for 5 cycles with A=2, B=9.
  → LT=1 and ID held stable; o_REQ_READY stays 0 throughout; response is released on the first i_RSP_READY=1.
- Reset while in COMPARE (A=8, B=1).
  → next cycle o_RSP_VALID=0, o_BUSY=0; no response emitted; the next grant starts from requester 0.
- Fairness: req1 and req3 held valid, rr_ptr=2.
  → grant 3 then 1 then 3; a valid that drops while not granted is never granted.
- With FBC_SCHED_SIGNED_EN: A=4'hF, B=4'h1 → LT=1. Without the macro: same inputs → GT=1.
